rc4_encrypt: RTL and testbench
==============================

Name: rc4_encrypt

Overview:
- ARC4 encryptor: the write-side counterpart of the ciphertext-consuming crack and decrypt blocks.
- Reads a length-prefixed plaintext from an external 256x8 pt memory, runs ARC4 key scheduling in an external 256x8 S memory, and writes a length-prefixed ciphertext into the ct memory.
- The output ct memory is the format the decrypt/crack datapath consumes.
- Started by an en/rdy handshake from a top-level controller.

Parameters:
KEY_BYTES, 3, key length in bytes; key port width is 8*KEY_BYTES; key byte 0 is the most significant byte

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
en  input  1  start request; honoured only while rdy=1
rdy  output  1  idle/ready flag
key  input  8*KEY_BYTES  encryption key, sampled on en acceptance
s_addr  output  8  S memory address
s_wrdata  output  8  S memory write data
s_wren  output  1  S memory write enable
s_rddata  input  8  S memory read data
pt_addr  output  8  plaintext memory address
pt_rddata  input  8  plaintext memory read data
ct_addr  output  8  ciphertext memory address
ct_wrdata  output  8  ciphertext memory write data
ct_wren  output  1  ciphertext memory write enable

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE, rdy=1, all addresses, wrdata and wren = 0, i/j/k counters = 0. This applies mid-operation too; memory contents are then undefined.
- Memories: synchronous read with one-cycle latency. The address driven in cycle A is sampled from rddata at the end of cycle A+1.
- Handshake:
  - In IDLE, rdy=1. en=1 at an edge latches key and enters INIT; rdy=0 from that edge on.
  - en is ignored while rdy=0.
  - rdy returns to 1 on the edge after the final ct write.
- INIT: 256 cycles; cycle n writes S[n]=n.
- KSA: for i=0..255, 6 cycles each:
  - RD_I (s_addr=i)
  - GET_I (capture si; j=j+si+key_byte[i mod KEY_BYTES])
  - RD_J (s_addr=j)
  - GET_J (capture sj)
  - WR_I (S[i]=sj)
  - WR_J (S[j]=si)
  - i mod KEY_BYTES uses a wrapping counter, not a divider.
- LEN: 3 cycles. Read pt[0], wait, write ct[0]=pt[0] unencrypted. L=pt[0].
- PRGA: i=j=0 at entry; for k=1..L, 9 cycles each:
  - i=i+1
  - RD_I, GET_I (j=j+si), RD_J, GET_J, WR_I, WR_J
  - RD_PAD (s_addr=si+sj, pt_addr=k)
  - GET_PAD
  - WR_CT (ct[k]=pt[k] xor pad)
- Arithmetic: all i/j/address sums are 8-bit modulo 256; the i==j swap is legal and writes the same value twice.
- Latency: exactly 1795+9L cycles from the accepting edge to the edge raising rdy; independent of data.
- Boundaries:
  - L=0: only ct[0]=0 is written; rdy after 1795 cycles.
  - L=255: k runs to 255 without wrap. The k counter is 9-bit or the terminate test precedes the increment.
- Exactly one memory write enable is asserted per cycle at most, and never in GET_/RD_ states.
- Ciphertext writes occur only at addresses 0..L.

Decomposition:
- Package rc4_pkg:
  - state enum (IDLE, INIT, KSA_*, LEN_*, PRGA_*)
  - S_SIZE=256
  - byte_t typedef
  - CYCLES_INIT=256, CYCLES_KSA_ITER=6, CYCLES_PRGA_ITER=9, CYCLES_LEN=3
- One natural sub-module, rc4_swap: the RD_I/GET_I/RD_J/GET_J/WR_I/WR_J sequencer.
  - Shared by KSA and PRGA; a j-increment input selects (si+key byte) or (si).
  - Exposes si/sj to the parent.

Test Plan:
1. Reset then key=24'h4B6579 ("Key"), pt = 9,"Plaintext" -> ct = 09 BB F3 16 E8 D9 40 AF 0A D3; rdy rises exactly 1876 cycles after en accepted.
2. Round trip: encrypt a random 40-byte message under key=24'h1E4600, load the result as pt, encrypt again with the same key -> output equals the original plaintext byte-for-byte.
3. Length 0: pt[0]=0 -> ct[0]=0; no ct_wren at any other address; rdy after 1795 cycles.
4. Length 255, key=24'hFFFFFF -> 256 ct writes (addresses 0..255, each once), no k wrap, rdy after 4090 cycles; ct matches the software model.
5. en pulsed repeatedly while busy, key changed mid-run -> output identical to scenario 1; en is only honoured once rdy=1.
6. rst_n=0 for one cycle during KSA -> next cycle rdy=1, all wren=0; a subsequent en with scenario 1 stimulus reproduces the scenario 1 ct exactly.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and cycle constants
// for the ARC4 encryptor and its swap sequencer.
package rc4_pkg;

  localparam int S_SIZE           = 256;
  localparam int CYCLES_INIT      = 256;
  localparam int CYCLES_KSA_ITER  = 6;
  localparam int CYCLES_PRGA_ITER = 9;
  localparam int CYCLES_LEN       = 3;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    KSA_SWAP,
    LEN_RD,
    LEN_GET,
    LEN_WR,
    PRGA_SWAP,
    PRGA_RD_PAD,
    PRGA_GET_PAD,
    PRGA_WR_CT
  } state_t;

  typedef enum logic [2:0] {
    SW_RD_I,
    SW_GET_I,
    SW_RD_J,
    SW_GET_J,
    SW_WR_I,
    SW_WR_J
  } swap_t;

endpackage

// File: rtl/rc4_swap.sv
// rc4_swap: six-cycle read/read/write/write swap
// of S[i] and S[j], shared by KSA and PRGA.
module rc4_swap
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       j_clr,
  input  logic [7:0] i,
  input  logic [7:0] inc,
  input  logic [7:0] rddata,
  output logic [7:0] addr,
  output logic [7:0] wrdata,
  output logic       wren,
  output logic [7:0] si,
  output logic [7:0] sj,
  output logic       last
);

  swap_t st, st_nxt;
  byte_t j;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= SW_RD_I;
      j  <= '0;
      si <= '0;
      sj <= '0;
    end else begin
      st <= st_nxt;
      if (j_clr)
        j <= '0;
      else if (go && st == SW_GET_I)
        j <= j + rddata + inc;
      if (go && st == SW_GET_I)
        si <= rddata;
      if (go && st == SW_GET_J)
        sj <= rddata;
    end
  end

  // Sequencer parks in SW_RD_I whenever go drops.
  always_comb begin
    st_nxt = SW_RD_I;
    addr   = i;
    wrdata = '0;
    wren   = 1'b0;
    last   = 1'b0;
    if (go) begin
      unique case (st)
        SW_RD_I:  st_nxt = SW_GET_I;
        SW_GET_I: st_nxt = SW_RD_J;
        SW_RD_J: begin
          st_nxt = SW_GET_J;
          addr   = j;
        end
        SW_GET_J: begin
          st_nxt = SW_WR_I;
          addr   = j;
        end
        SW_WR_I: begin
          st_nxt = SW_WR_J;
          wrdata = sj;
          wren   = 1'b1;
        end
        SW_WR_J: begin
          st_nxt = SW_RD_I;
          addr   = j;
          wrdata = si;
          wren   = 1'b1;
          last   = 1'b1;
        end
        default: st_nxt = SW_RD_I;
      endcase
    end
  end

endmodule

// File: rtl/rc4_encrypt.sv
// rc4_encrypt: ARC4 encryptor, length-prefixed
// plaintext memory in, length-prefixed ciphertext out.
module rc4_encrypt
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  state_t                 st, st_nxt;
  byte_t                  i, k, len, pad, ptb;
  logic [KW-1:0]          kidx;
  logic [8*KEY_BYTES-1:0] key_r;
  byte_t                  key_byte;

  logic  go, j_clr, sw_wren, sw_last;
  byte_t inc, sw_addr, sw_wrdata, si, sj;

  assign go    = (st == KSA_SWAP) || (st == PRGA_SWAP);
  assign j_clr = (st == INIT) || (st == LEN_WR);
  assign inc   = (st == KSA_SWAP) ? key_byte : '0;

  // Byte 0 of the key sits in the top bits.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      if (kidx == KW'(b))
        key_byte = key_r[8*(KEY_BYTES-1-b) +: 8];
  end

  rc4_swap u_swap (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .j_clr  (j_clr),
    .i      (i),
    .inc    (inc),
    .rddata (s_rddata),
    .addr   (sw_addr),
    .wrdata (sw_wrdata),
    .wren   (sw_wren),
    .si     (si),
    .sj     (sj),
    .last   (sw_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      st <= IDLE;
    else
      st <= st_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i     <= '0;
      k     <= '0;
      kidx  <= '0;
      len   <= '0;
      pad   <= '0;
      ptb   <= '0;
      key_r <= '0;
    end else begin
      unique case (st)
        IDLE: if (en) begin
          key_r <= key;
          i     <= '0;
          kidx  <= '0;
        end
        INIT: i <= i + 1'b1;
        KSA_SWAP: if (sw_last) begin
          i    <= i + 1'b1;
          kidx <= (kidx == KW'(KEY_BYTES-1)) ? '0 : kidx + 1'b1;
        end
        LEN_GET: len <= pt_rddata;
        LEN_WR: begin
          i <= 8'd1;
          k <= 8'd1;
        end
        PRGA_GET_PAD: begin
          pad <= s_rddata;
          ptb <= pt_rddata;
        end
        // k is tested against len before it steps, so 255 never wraps.
        PRGA_WR_CT: begin
          i <= i + 1'b1;
          k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_nxt    = st;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    unique case (st)
      IDLE: begin
        rdy = 1'b1;
        if (en)
          st_nxt = INIT;
      end
      INIT: begin
        s_addr   = i;
        s_wrdata = i;
        s_wren   = 1'b1;
        if (i == byte_t'(S_SIZE-1))
          st_nxt = KSA_SWAP;
      end
      KSA_SWAP: begin
        s_addr   = sw_addr;
        s_wrdata = sw_wrdata;
        s_wren   = sw_wren;
        if (sw_last && i == byte_t'(S_SIZE-1))
          st_nxt = LEN_RD;
      end
      LEN_RD:  st_nxt = LEN_GET;
      LEN_GET: st_nxt = LEN_WR;
      LEN_WR: begin
        ct_wrdata = len;
        ct_wren   = 1'b1;
        st_nxt    = (len == '0) ? IDLE : PRGA_SWAP;
      end
      PRGA_SWAP: begin
        s_addr   = sw_addr;
        s_wrdata = sw_wrdata;
        s_wren   = sw_wren;
        if (sw_last)
          st_nxt = PRGA_RD_PAD;
      end
      PRGA_RD_PAD: begin
        s_addr  = si + sj;
        pt_addr = k;
        st_nxt  = PRGA_GET_PAD;
      end
      PRGA_GET_PAD: st_nxt = PRGA_WR_CT;
      PRGA_WR_CT: begin
        ct_addr   = k;
        ct_wrdata = ptb ^ pad;
        ct_wren   = 1'b1;
        st_nxt    = (k == len) ? IDLE : PRGA_SWAP;
      end
      default: st_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_encrypt.sv
// tb_rc4_encrypt: directed vectors for the ARC4
// encryptor against behavioural S/pt/ct memories.
module tb_rc4_encrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] key = '0;
  logic        rdy;
  logic [7:0]  s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata;
  logic        s_wren, ct_wren;
  logic [7:0]  s_rddata = '0;
  logic [7:0]  pt_rddata = '0;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] exp_ct [256];
  logic [7:0] orig   [256];
  int         ct_cnt [256];
  int         n_both = 0;
  bit         clr = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] v1 [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8,
                          8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  always #5 clk = ~clk;

  rc4_encrypt #(.KEY_BYTES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .s_addr    (s_addr),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .s_rddata  (s_rddata),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  always @(posedge clk) begin
    if (s_wren)
      s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (clr) begin
      for (int a = 0; a < 256; a++) begin
        ct_cnt[a] <= 0;
        ct_mem[a] <= 8'hAA;
      end
    end else if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      ct_cnt[ct_addr] <= ct_cnt[ct_addr] + 1;
    end
    if (s_wren && ct_wren)
      n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_ct();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic run(input logic [23:0] k, input bit pulse,
                     output int cyc);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    cyc = 0;
    while (!rdy && cyc < 6000) begin
      if (pulse) begin
        en  = cyc[0];
        key = 24'($urandom);
      end
      @(posedge clk);
      #1 cyc++;
    end
    en = 1'b0;
  endtask

  // Counts addresses not written exactly once in 0..len, plus any write beyond len.
  function automatic int bad_writes(input int len);
    int b = 0;
    for (int a = 0; a < 256; a++)
      if (a <= len) b += (ct_cnt[a] != 1) ? 1 : 0;
      else          b += ct_cnt[a];
    return b;
  endfunction

  function automatic int ct_diff(input int len);
    int d = 0;
    for (int n = 0; n <= len; n++)
      if (ct_mem[n] !== exp_ct[n]) d++;
    return d;
  endfunction

  task automatic model(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] t, a, b, kb, pi;
    int len;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    b = '0;
    for (int n = 0; n < 256; n++) begin
      kb = (n % 3 == 0) ? k[23:16] : (n % 3 == 1) ? k[15:8] : k[7:0];
      b = b + s[n] + kb;
      t = s[n]; s[n] = s[b]; s[b] = t;
    end
    len = int'(pt_mem[0]);
    exp_ct[0] = pt_mem[0];
    a = '0;
    b = '0;
    for (int n = 1; n <= len; n++) begin
      a = a + 8'd1;
      b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      pi = s[a] + s[b];
      exp_ct[n] = pt_mem[n] ^ s[pi];
    end
  endtask

  task automatic load_sc1();
    string p;
    p = "Plaintext";
    pt_mem[0] = 8'd9;
    for (int n = 0; n < 9; n++) pt_mem[n+1] = p[n];
    for (int n = 0; n < 10; n++) exp_ct[n] = v1[n];
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", int'(rdy), 1);
    chk("rst_wren", int'({s_wren, ct_wren}), 0);
    chk("rst_addr", int'({s_addr, pt_addr, ct_addr}), 0);
    chk("rst_wrdata", int'({s_wrdata, ct_wrdata}), 0);
    @(negedge clk) rst_n = 1'b1;

    load_sc1();
    clear_ct();
    run(24'h4B6579, 1'b0, cyc);
    chk("sc1_latency", cyc, 1876);
    for (int n = 0; n < 10; n++)
      chk($sformatf("sc1_ct%0d", n), int'(ct_mem[n]), int'(v1[n]));
    chk("sc1_writes", bad_writes(9), 0);

    clear_ct();
    run(24'h4B6579, 1'b1, cyc);
    chk("sc5_latency", cyc, 1876);
    chk("sc5_ct", ct_diff(9), 0);
    chk("sc5_writes", bad_writes(9), 0);
    repeat (3) @(posedge clk);
    #1 chk("sc5_idle", int'(rdy), 1);

    @(negedge clk);
    key = 24'h4B6579;
    en  = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (600) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("sc6_rst_rdy", int'(rdy), 1);
    chk("sc6_rst_wren", int'({s_wren, ct_wren}), 0);
    chk("sc6_rst_addr", int'({s_addr, pt_addr, ct_addr}), 0);
    @(negedge clk) rst_n = 1'b1;
    clear_ct();
    run(24'h4B6579, 1'b0, cyc);
    chk("sc6_latency", cyc, 1876);
    chk("sc6_ct", ct_diff(9), 0);

    pt_mem[0] = 8'd40;
    for (int n = 1; n <= 40; n++) pt_mem[n] = 8'($urandom);
    for (int n = 0; n <= 40; n++) orig[n] = pt_mem[n];
    model(24'h1E4600);
    clear_ct();
    run(24'h1E4600, 1'b0, cyc);
    chk("sc2_latency", cyc, 2155);
    chk("sc2_ct_model", ct_diff(40), 0);
    for (int n = 0; n <= 40; n++) pt_mem[n] = ct_mem[n];
    for (int n = 0; n <= 40; n++) exp_ct[n] = orig[n];
    clear_ct();
    run(24'h1E4600, 1'b0, cyc);
    chk("sc2_rt_latency", cyc, 2155);
    chk("sc2_roundtrip", ct_diff(40), 0);

    pt_mem[0] = 8'd0;
    clear_ct();
    run(24'h4B6579, 1'b0, cyc);
    chk("sc3_latency", cyc, 1795);
    chk("sc3_ct0", int'(ct_mem[0]), 0);
    chk("sc3_writes", bad_writes(0), 0);

    pt_mem[0] = 8'd255;
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
    model(24'hFFFFFF);
    clear_ct();
    run(24'hFFFFFF, 1'b0, cyc);
    chk("sc4_latency", cyc, 4090);
    chk("sc4_ct0", int'(ct_mem[0]), 255);
    chk("sc4_ct_model", ct_diff(255), 0);
    chk("sc4_writes", bad_writes(255), 0);

    chk("wren_overlap", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
